// File: rtl/rf_wb_arbiter_pkg.sv
// Shared core constants and types for the register-file writeback path.
package rf_wb_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Identifies the requester that last won the write port (0=A, 1=B).
  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Pending-write bitmap: one bit per architectural register, set on issue and
// cleared on writeback. When both hit the same bit on one edge, the set wins.
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  output logic [NUM_REGS-1:0]   pend
);

  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_next;

  always_comb begin
    pend_next = pend_q;
    if (clr_en) pend_next[clr_addr] = 1'b0;
    // Set is applied after the clear so a re-issue survives a same-edge writeback.
    if (set_en) pend_next[set_addr] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_next;
    end
  end

  assign pend = pend_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter between the ALU (A) and load unit (B) for the single
// register-file write port, with a registered write stage and pending bitmap.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [XLEN-1:0]       a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [XLEN-1:0]       b_data,
  output logic                  b_ready,
  input  logic                  hold,
  input  logic                  issue_en,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  output logic                  we3,
  output logic [REG_ADDR_W-1:0] wa3,
  output logic [XLEN-1:0]       wd3,
  output logic [NUM_REGS-1:0]   pend
);

  // Handshake: a transfer happens on a cycle where valid && ready. ready is a
  // combinational function of both valids, hold, rst and last_grant, and never
  // depends on addr/data. A requester may drop valid at any time without a
  // transfer; addr/data are only sampled on the transfer cycle.

  grant_e  last_grant;
  logic    a_xfer;
  logic    b_xfer;
  wb_req_t winner;
  logic    winner_we;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst && !hold) begin
      // Contested cycles go to whoever did not win last time.
      a_ready = a_valid && (!b_valid || (last_grant == GRANT_B));
      b_ready = b_valid && (!a_valid || (last_grant == GRANT_A));
    end
  end

  assign a_xfer = a_valid && a_ready;
  assign b_xfer = b_valid && b_ready;

  always_comb begin
    winner = '{addr: b_addr, data: b_data};
    if (a_xfer) winner = '{addr: a_addr, data: a_data};
  end

  // x0 is hardwired zero: the transfer is accepted but never written.
  assign winner_we = (a_xfer || b_xfer) && !is_zero_reg(winner.addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_B;
      we3        <= 1'b0;
      wa3        <= '0;
      wd3        <= '0;
    end else begin
      we3 <= winner_we;
      if (a_xfer || b_xfer) begin
        last_grant <= a_xfer ? GRANT_A : GRANT_B;
        wa3        <= winner.addr;
        wd3        <= winner.data;
      end
    end
  end

  rf_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_en && !is_zero_reg(issue_addr)),
    .set_addr (issue_addr),
    .clr_en   (we3),
    .clr_addr (wa3),
    .pend     (pend)
  );

  ready_onehot_a: assert property (@(posedge clk) disable iff (rst) !(a_ready && b_ready));

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-high reset, with ports in this order:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
REQ-002 The block SHALL have these ports:
- a_valid  in  1  ALU writeback request.
- a_addr  in  5  ALU destination register.
- a_data  in  32  ALU result.
- a_ready  out  1  ALU request accepted this cycle.
- b_valid  in  1  load-unit writeback request.
- b_addr  in  5  load-unit destination register.
- b_data  in  32  load data.
- b_ready  out  1  load request accepted this cycle.
- hold  in  1  pipeline freeze; blocks all grants.
- issue_en  in  1  instruction issued with a destination register.
- issue_addr  in  5  destination of the issued instruction.
- we3  out  1  register-file write enable.
- wa3  out  5  register-file write address.
- wd3  out  32  register-file write data.
- pend  out  32  per-register pending-write bitmap.

Function
REQ-003 a_ready and b_ready SHALL be combinational from the valids, hold and last_grant; they SHALL be mutually exclusive; a transfer is valid&&ready.
REQ-004 With hold=1, both readies SHALL be 0 and last_grant SHALL be held.
REQ-005 With exactly one valid and hold=0, that requester SHALL be granted.
REQ-006 With both valid and hold=0, the requester not named by last_grant SHALL be granted (round-robin).
REQ-007 On every transfer, last_grant SHALL be updated to the granted requester (0=A, 1=B).
REQ-008 we3/wa3/wd3 SHALL be registered: the edge ending a transfer cycle loads wa3/wd3 with the winner's addr/data, and we3 is 1 for exactly the following cycle.
REQ-009 With no transfer in a cycle, we3 SHALL be 0 the next cycle; wa3/wd3 SHALL hold their last values.
REQ-010 A transfer to address 0 SHALL be accepted (ready=1) but SHALL leave we3=0 the next cycle; x0 is never written.
REQ-011 Back-to-back transfers SHALL produce we3=1 on consecutive cycles; throughput is one write per cycle.
REQ-012 An edge with issue_en=1 and issue_addr!=0 SHALL set pend[issue_addr].
REQ-013 An edge with we3=1 SHALL clear pend[wa3].
REQ-014 When a set and a clear target the same bit on the same edge, the set SHALL win.
REQ-015 pend[0] SHALL be constant 0.
REQ-016 Requester valid/addr/data SHALL be sampled only in the transfer cycle; a requester may drop valid without a transfer.

Reset
REQ-017 While rst=1, the block SHALL force: we3=0, wa3=0, wd3=0, pend=0, last_grant=1 (A wins the first contest).
REQ-018 Reset SHALL take effect immediately, without waiting for a clock edge, and SHALL abort any staged write.
REQ-019 Readies SHALL be 0 while rst=1.
REQ-020 The first transfer SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-021 XLEN=32, REG_ADDR_W=5 and NUM_REGS=32 SHALL live in the shared core package; the block SHALL use only these, not literals.
REQ-022 The pending bitmap SHALL be a sub-module, rf_scoreboard: inputs set_en/set_addr/clr_en/clr_addr, output pend.
REQ-023 Arbitration and the write-port staging register SHALL stay in rf_wb_arbiter.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Reset, then a_valid=1, a_addr=5, a_data=DEADBEEF for one cycle -> a_ready=1; next cycle we3=1, wa3=5, wd3=DEADBEEF; the cycle after, we3=0.
- a and b valid for 4 cycles (a_addr=1, b_addr=2) -> grant order A,B,A,B; we3 asserted 4 consecutive cycles with wa3=1,2,1,2.
- hold=1 with both valid -> both readies 0 and we3=0; release hold -> A granted if last_grant was B.
- issue_en, issue_addr=7 -> pend[7]=1; B writes reg 7 -> pend[7]=0 at the edge where we3=1, wa3=7.
- Same edge: we3=1, wa3=9, plus issue_en, issue_addr=9 -> pend[9] stays 1.
- Write to x0 with data 12345678 -> ready=1, we3 stays 0; issue to x0 -> pend=0.
- rst asserted mid-cycle while a write is staged -> we3, pend drop to 0 before the next edge.
